// File: rtl/nes_mem_pkg.sv
// Shared types and widths for the NES PRG/CHR memory arbiter.
// Bus defaults match the 22-bit PRG+CHR image in byte-wide memory.
package nes_mem_pkg;
    localparam int NES_MEM_ADDR_W = 22;
    localparam int NES_MEM_DATA_W = 8;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_CPU,
        SRC_PPU,
        SRC_REF
    } arb_src_t;
endpackage

// File: rtl/nes_mem_arbiter_if.sv
// Client ports (CPU/PPU mapper side) and memory controller bus of the arbiter.
// slave: arbiter view; master: the surrounding system driving requests and acks.
interface nes_mem_arbiter_if
    import nes_mem_pkg::*;
#(
    parameter int ADDR_W = NES_MEM_ADDR_W,
    parameter int DATA_W = NES_MEM_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;
    logic              ppu_req;
    logic              ppu_we;
    logic [ADDR_W-1:0] ppu_addr;
    logic [DATA_W-1:0] ppu_wdata;
    logic [DATA_W-1:0] ppu_rdata;
    logic              ppu_done;
    logic [1:0]        overrun;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_refresh;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ppu_req, ppu_we, ppu_addr, ppu_wdata,
        input  mem_ack, mem_rdata,
        output cpu_rdata, cpu_done, ppu_rdata, ppu_done, overrun,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_refresh
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ppu_req, ppu_we, ppu_addr, ppu_wdata,
        output mem_ack, mem_rdata,
        input  cpu_rdata, cpu_done, ppu_rdata, ppu_done, overrun,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_refresh
    );
endinterface

// File: rtl/nes_mem_req_latch.sv
// Per-port request holder: pending flag, captured we/addr/wdata, sticky overrun.
// valid_o/fields pass the live request through so an idle arbiter can issue it at once.
module nes_mem_req_latch
    import nes_mem_pkg::*;
#(
    parameter int ADDR_W = NES_MEM_ADDR_W,
    parameter int DATA_W = NES_MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              clr_i,
    output logic              valid_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              overrun_o
);
    logic              pend_q, pend_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ovr_q, ovr_d;

    always_comb begin
        pend_d  = pend_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ovr_d   = ovr_q;
        if (req_i && !pend_q) begin
            pend_d  = 1'b1;
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end else begin
            if (req_i) ovr_d = 1'b1;
            if (clr_i) pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ovr_q   <= ovr_d;
        end
    end

    assign valid_o   = pend_q | req_i;
    assign we_o      = pend_q ? we_q : we_i;
    assign addr_o    = pend_q ? addr_q : addr_i;
    assign wdata_o   = pend_q ? wdata_q : wdata_i;
    assign overrun_o = ovr_q;
endmodule

// File: rtl/nes_mem_arbiter.sv
// Shares one byte-wide PRG/CHR memory between the CPU and PPU mapper ports.
// Define MEM_REFRESH_EN to add periodic refresh transactions ahead of client traffic.
module nes_mem_arbiter
    import nes_mem_pkg::*;
#(
    parameter int ADDR_W           = NES_MEM_ADDR_W,
    parameter int DATA_W           = NES_MEM_DATA_W,
    parameter bit PPU_PRIORITY     = 1'b1,
    parameter int REFRESH_INTERVAL = 390
) (
    input  logic             clk,
    input  logic             reset_n,
    nes_mem_arbiter_if.slave bus
);
    arb_state_t        state_q, state_d;
    arb_src_t          src_q, src_d, last_q, last_d;
    logic              mreq_q, mreq_d, mwe_q, mwe_d, mref_q, mref_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic              cdone_q, cdone_d, pdone_q, pdone_d;
    logic [DATA_W-1:0] crdata_q, crdata_d, prdata_q, prdata_d;
    logic              cpu_v, cpu_we, ppu_v, ppu_we, cpu_ovr, ppu_ovr;
    logic [ADDR_W-1:0] cpu_addr, ppu_addr;
    logic [DATA_W-1:0] cpu_wdata, ppu_wdata;
    logic              ack, cpu_clr, ppu_clr, ref_pend;
    logic              tie_ppu, gnt_ref, gnt_ppu, gnt_cpu;

    assign ack     = (state_q == ST_BUSY) && bus.mem_ack;
    assign cpu_clr = ack && (src_q == SRC_CPU);
    assign ppu_clr = ack && (src_q == SRC_PPU);

    nes_mem_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cpu (
        .clk(clk), .reset_n(reset_n), .req_i(bus.cpu_req), .we_i(bus.cpu_we),
        .addr_i(bus.cpu_addr), .wdata_i(bus.cpu_wdata), .clr_i(cpu_clr),
        .valid_o(cpu_v), .we_o(cpu_we), .addr_o(cpu_addr), .wdata_o(cpu_wdata),
        .overrun_o(cpu_ovr)
    );

    nes_mem_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ppu (
        .clk(clk), .reset_n(reset_n), .req_i(bus.ppu_req), .we_i(bus.ppu_we),
        .addr_i(bus.ppu_addr), .wdata_i(bus.ppu_wdata), .clr_i(ppu_clr),
        .valid_o(ppu_v), .we_o(ppu_we), .addr_o(ppu_addr), .wdata_o(ppu_wdata),
        .overrun_o(ppu_ovr)
    );

`ifdef MEM_REFRESH_EN
    localparam int REF_W = $clog2(REFRESH_INTERVAL);
    logic [REF_W-1:0] rcnt_q, rcnt_d;
    logic             rpend_q, rpend_d, rwrap, ref_clr;

    assign ref_clr = ack && (src_q == SRC_REF);
    assign rwrap   = (rcnt_q == REF_W'(REFRESH_INTERVAL - 1));
    assign rcnt_d  = rwrap ? '0 : rcnt_q + REF_W'(1);
    // A wrap while a refresh is still outstanding merges into it.
    assign rpend_d = (rpend_q && !ref_clr) || rwrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcnt_q  <= '0;
            rpend_q <= 1'b0;
        end else begin
            rcnt_q  <= rcnt_d;
            rpend_q <= rpend_d;
        end
    end

    assign ref_pend = rpend_q;
`else
    assign ref_pend = (REFRESH_INTERVAL < 0);
`endif

    // Round-robin ties go to the port not served last; reset leaves last=CPU.
    assign tie_ppu = PPU_PRIORITY || (last_q == SRC_CPU);
    assign gnt_ref = ref_pend;
    assign gnt_ppu = !ref_pend && ppu_v && (!cpu_v || tie_ppu);
    assign gnt_cpu = !ref_pend && cpu_v && !gnt_ppu;

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        last_d   = last_q;
        mreq_d   = mreq_q;
        mwe_d    = mwe_q;
        mref_d   = mref_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        cdone_d  = 1'b0;
        pdone_d  = 1'b0;
        crdata_d = crdata_q;
        prdata_d = prdata_q;
        unique case (state_q)
            ST_IDLE: begin
                unique case (1'b1)
                    gnt_ref: begin
                        src_d    = SRC_REF;
                        mwe_d    = 1'b0;
                        mref_d   = 1'b1;
                        maddr_d  = '0;
                        mwdata_d = '0;
                    end
                    gnt_ppu: begin
                        src_d    = SRC_PPU;
                        last_d   = SRC_PPU;
                        mwe_d    = ppu_we;
                        mref_d   = 1'b0;
                        maddr_d  = ppu_addr;
                        mwdata_d = ppu_wdata;
                    end
                    gnt_cpu: begin
                        src_d    = SRC_CPU;
                        last_d   = SRC_CPU;
                        mwe_d    = cpu_we;
                        mref_d   = 1'b0;
                        maddr_d  = cpu_addr;
                        mwdata_d = cpu_wdata;
                    end
                    default: ;
                endcase
                if (gnt_ref || gnt_ppu || gnt_cpu) begin
                    state_d = ST_BUSY;
                    mreq_d  = 1'b1;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ack) begin
                    state_d  = ST_IDLE;
                    mreq_d   = 1'b0;
                    mwe_d    = 1'b0;
                    mref_d   = 1'b0;
                    maddr_d  = '0;
                    mwdata_d = '0;
                    unique case (src_q)
                        SRC_CPU: begin
                            cdone_d = 1'b1;
                            if (!mwe_q) crdata_d = bus.mem_rdata;
                        end
                        SRC_PPU: begin
                            pdone_d = 1'b1;
                            if (!mwe_q) prdata_d = bus.mem_rdata;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            src_q    <= SRC_CPU;
            last_q   <= SRC_CPU;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            mref_q   <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            cdone_q  <= 1'b0;
            pdone_q  <= 1'b0;
            crdata_q <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            last_q   <= last_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            mref_q   <= mref_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            cdone_q  <= cdone_d;
            pdone_q  <= pdone_d;
            crdata_q <= crdata_d;
            prdata_q <= prdata_d;
        end
    end

    assign bus.mem_req     = mreq_q;
    assign bus.mem_we      = mwe_q;
    assign bus.mem_addr    = maddr_q;
    assign bus.mem_wdata   = mwdata_q;
    assign bus.mem_refresh = mref_q;
    assign bus.cpu_done    = cdone_q;
    assign bus.ppu_done    = pdone_q;
    assign bus.cpu_rdata   = crdata_q;
    assign bus.ppu_rdata   = prdata_q;
    assign bus.overrun     = {ppu_ovr, cpu_ovr};
endmodule
